powerpc_ram_arbiter: RTL and testbench

Round-robin arbiter that shares the two ports of the dual-port 8x64 PowerPC RAM among four requesters (fetch, load/store, DMA, debug). Each cycle it grants up to two requests, one per RAM port. It resolves same-address hazards between the ports and returns read data with a one-cycle valid strobe. It sits between the requesters and the RAM and is the only master of the RAM's `Data_*`, `Addr_*` and `ENW_*` inputs.

---
 rtl/powerpc_ram_pkg.sv | 22 ++
 rtl/ram_rr_picker.sv | 36 +++
 rtl/powerpc_ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_powerpc_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/powerpc_ram_pkg.sv
// Shared definitions for the PowerPC dual-port RAM arbiter.
// RAM geometry (64 words x 8 bits), requester ids and the per-port read tag.
package powerpc_ram_pkg;

  localparam int RAM_AW   = 6;
  localparam int RAM_DW   = 8;
  localparam int RAM_NREQ = 4;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'd0,
    REQ_LS    = 2'd1,
    REQ_DMA   = 2'd2,
    REQ_DBG   = 2'd3
  } req_id_e;

  // Outstanding read on one RAM port: which requester gets q next cycle.
  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } port_tag_t;

endpackage

// File: rtl/ram_rr_picker.sv
// Combinational round-robin picker.
// Finds the first requester with (req & mask) set, scanning upward from
// rr_ptr with wrap-around.
//   req    : request vector
//   rr_ptr : highest-priority index
//   mask   : candidates allowed for this pick
//   found  : some candidate exists
//   idx    : index of the chosen candidate (rr_ptr when nothing found)
module ram_rr_picker
  import powerpc_ram_pkg::*;
(
  input  logic [RAM_NREQ-1:0] req,
  input  logic [1:0]          rr_ptr,
  input  logic [RAM_NREQ-1:0] mask,
  output logic                found,
  output logic [1:0]          idx
);

  logic [RAM_NREQ-1:0] cand;

  assign cand = req & mask;

  // Walk offsets from farthest to nearest so the nearest hit is the last
  // assignment and wins.
  always_comb begin
    found = 1'b0;
    idx   = rr_ptr;
    for (int i = RAM_NREQ - 1; i >= 0; i--) begin
      if (cand[rr_ptr + 2'(i)]) begin
        found = 1'b1;
        idx   = rr_ptr + 2'(i);
      end
    end
  end

endmodule

// File: rtl/powerpc_ram_arbiter.sv
// Round-robin arbiter sharing the two ports of the 64x8 dual-port PowerPC RAM
// among four requesters (fetch, load/store, DMA, debug).
//   CLK, RST            : clock, synchronous active-high reset
//   req/we/addr/wdata   : per-requester request, held until gnt
//   gnt                 : one-cycle grant pulse (combinational)
//   rvalid/rdata        : read return one cycle after a read grant
//   Data_x/Addr_x/ENW_x : RAM port drive (port A = pick 1, port B = pick 2)
//   q_A, q_B            : RAM registered read data
module powerpc_ram_arbiter
  import powerpc_ram_pkg::*;
#(
  parameter int NREQ = RAM_NREQ,
  parameter int AW   = RAM_AW,
  parameter int DW   = RAM_DW
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic [DW-1:0]      Data_A,
  output logic [DW-1:0]      Data_B,
  output logic [AW-1:0]      Addr_A,
  output logic [AW-1:0]      Addr_B,
  output logic               ENW_A,
  output logic               ENW_B,
  input  logic [DW-1:0]      q_A,
  input  logic [DW-1:0]      q_B
);

  logic [1:0]    rr_ptr;
  port_tag_t     tag_a;
  port_tag_t     tag_b;
  logic [AW-1:0] hold_addr_a;
  logic [AW-1:0] hold_addr_b;
  logic [DW-1:0] hold_data_a;
  logic [DW-1:0] hold_data_b;

  logic [AW-1:0] addr_v  [NREQ];
  logic [DW-1:0] wdata_v [NREQ];

  logic          p1_found;
  logic          p2_found;
  logic [1:0]    p1_idx;
  logic [1:0]    p2_idx;
  logic [NREQ-1:0] p2_mask;
  logic          hazard;
  logic          gnt_a;
  logic          gnt_b;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_v[i]  = addr[i*AW +: AW];
      wdata_v[i] = wdata[i*DW +: DW];
    end
  end

  ram_rr_picker u_pick_a (
    .req    (req),
    .rr_ptr (rr_ptr),
    .mask   ({NREQ{1'b1}}),
    .found  (p1_found),
    .idx    (p1_idx)
  );

  // Same scan with pick 1 removed yields the next requester after it.
  assign p2_mask = ~(NREQ'(1) << p1_idx);

  ram_rr_picker u_pick_b (
    .req    (req),
    .rr_ptr (rr_ptr),
    .mask   (p2_mask),
    .found  (p2_found),
    .idx    (p2_idx)
  );

  // Same address on both ports is only safe when both are reads.
  assign hazard = p2_found && (addr_v[p1_idx] == addr_v[p2_idx]) &&
                  (we[p1_idx] || we[p2_idx]);

  assign gnt_a = p1_found && !RST;
  assign gnt_b = p2_found && !hazard && !RST;

  always_comb begin
    gnt = '0;
    if (gnt_a) gnt[p1_idx] = 1'b1;
    if (gnt_b) gnt[p2_idx] = 1'b1;
  end

  always_comb begin
    if (RST) begin
      Addr_A = '0;
      Data_A = '0;
      Addr_B = '0;
      Data_B = '0;
    end else begin
      Addr_A = gnt_a ? addr_v[p1_idx]  : hold_addr_a;
      Data_A = gnt_a ? wdata_v[p1_idx] : hold_data_a;
      Addr_B = gnt_b ? addr_v[p2_idx]  : hold_addr_b;
      Data_B = gnt_b ? wdata_v[p2_idx] : hold_data_b;
    end
  end

  assign ENW_A = gnt_a && we[p1_idx];
  assign ENW_B = gnt_b && we[p2_idx];

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr      <= 2'd0;
      tag_a       <= '0;
      tag_b       <= '0;
      hold_addr_a <= '0;
      hold_addr_b <= '0;
      hold_data_a <= '0;
      hold_data_b <= '0;
    end else begin
      tag_a <= '{valid: gnt_a && !we[p1_idx], id: p1_idx};
      tag_b <= '{valid: gnt_b && !we[p2_idx], id: p2_idx};
      if (gnt_a) begin
        hold_addr_a <= addr_v[p1_idx];
        hold_data_a <= wdata_v[p1_idx];
      end
      if (gnt_b) begin
        hold_addr_b <= addr_v[p2_idx];
        hold_data_b <= wdata_v[p2_idx];
      end
      if (gnt_b) begin
        rr_ptr <= p2_idx + 2'd1;
      end else if (gnt_a) begin
        rr_ptr <= p1_idx + 2'd1;
      end
    end
  end

  // A requester never holds both tags, so the two ports cannot collide here.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (!RST) begin
      if (tag_a.valid) begin
        rvalid[tag_a.id]          = 1'b1;
        rdata[tag_a.id*DW +: DW]  = q_A;
      end
      if (tag_b.valid) begin
        rvalid[tag_b.id]          = 1'b1;
        rdata[tag_b.id*DW +: DW]  = q_B;
      end
    end
  end

endmodule

// File: tb/tb_powerpc_ram_arbiter.sv
module tb_powerpc_ram_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [31:0] rdata;
  logic [7:0]  Data_A, Data_B;
  logic [5:0]  Addr_A, Addr_B;
  logic        ENW_A, ENW_B;
  logic [7:0]  q_A, q_B;

  int n_cmp = 0;
  int n_bad = 0;

  powerpc_ram_arbiter dut (
    .CLK    (CLK),
    .RST    (RST),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata),
    .Data_A (Data_A),
    .Data_B (Data_B),
    .Addr_A (Addr_A),
    .Addr_B (Addr_B),
    .ENW_A  (ENW_A),
    .ENW_B  (ENW_B),
    .q_A    (q_A),
    .q_B    (q_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM: synchronous write, registered read-first output.
  logic [7:0] ram [64];
  initial for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
  always @(posedge CLK) begin
    if (ENW_A) ram[Addr_A] <= Data_A;
    if (ENW_B) ram[Addr_B] <= Data_B;
    q_A <= ram[Addr_A];
    q_B <= ram[Addr_B];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_rr = 0;
  bit         m_tv [2];
  logic [1:0] m_tid [2];
  logic [7:0] m_td [2];
  logic [5:0] m_ha [2];
  logic [7:0] m_hd [2];
  logic [7:0] m_mem [64];
  int         pk [2];
  int         j;
  logic [3:0]  e_gnt, e_rv;
  logic [31:0] e_rd;
  logic        e_enw [2];
  logic [5:0]  e_ad [2];
  logic [7:0]  e_dt [2];

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_tv[k] = 0; m_tid[k] = 0; m_td[k] = 0; m_ha[k] = 0; m_hd[k] = 0;
    end
  end

  always @(negedge CLK) begin
    e_gnt = '0; e_rv = '0; e_rd = '0;
    pk[0] = -1; pk[1] = -1;
    for (int k = 0; k < 2; k++) begin
      e_enw[k] = 1'b0; e_ad[k] = m_ha[k]; e_dt[k] = m_hd[k];
    end
    if (RST) begin
      for (int k = 0; k < 2; k++) begin e_ad[k] = 0; e_dt[k] = 0; end
    end else begin
      for (int i = 0; i < 4; i++) begin
        j = (m_rr + i) % 4;
        if (req[j]) begin
          if (pk[0] < 0) pk[0] = j;
          else if (pk[1] < 0) pk[1] = j;
        end
      end
      if (pk[1] >= 0 && addr[pk[0]*6 +: 6] == addr[pk[1]*6 +: 6] &&
          (we[pk[0]] || we[pk[1]])) pk[1] = -1;
      for (int k = 0; k < 2; k++) begin
        if (pk[k] >= 0) begin
          e_gnt[pk[k]] = 1'b1;
          e_ad[k]  = addr[pk[k]*6 +: 6];
          e_dt[k]  = wdata[pk[k]*8 +: 8];
          e_enw[k] = we[pk[k]];
        end
        if (m_tv[k]) begin
          e_rv[m_tid[k]] = 1'b1;
          e_rd[m_tid[k]*8 +: 8] = m_td[k];
        end
      end
    end
    chk("gnt",    gnt,    e_gnt);
    chk("rvalid", rvalid, e_rv);
    chk("rdata",  rdata,  e_rd);
    chk("ENW_A",  ENW_A,  e_enw[0]);
    chk("ENW_B",  ENW_B,  e_enw[1]);
    chk("Addr_A", Addr_A, e_ad[0]);
    chk("Addr_B", Addr_B, e_ad[1]);
    chk("Data_A", Data_A, e_dt[0]);
    chk("Data_B", Data_B, e_dt[1]);
    // state as of the coming edge
    if (RST) begin
      m_rr = 0;
      for (int k = 0; k < 2; k++) begin m_tv[k] = 0; m_ha[k] = 0; m_hd[k] = 0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_tv[k] = (pk[k] >= 0) && !we[pk[k]];
        if (pk[k] >= 0) begin
          m_tid[k] = 2'(pk[k]);
          m_td[k]  = m_mem[addr[pk[k]*6 +: 6]];
          m_ha[k]  = e_ad[k];
          m_hd[k]  = e_dt[k];
        end
      end
      for (int k = 0; k < 2; k++)
        if (pk[k] >= 0 && we[pk[k]]) m_mem[e_ad[k]] = e_dt[k];
      if (pk[1] >= 0) m_rr = (pk[1] + 1) % 4;
      else if (pk[0] >= 0) m_rr = (pk[0] + 1) % 4;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [5:0] a, input logic [7:0] d);
    we[i] = w;
    addr[i*6 +: 6] = a;
    wdata[i*8 +: 8] = d;
  endtask

  logic [3:0] g_seen;

  initial begin
    RST = 1'b1; req = 4'b1111; we = '0; wdata = '0;
    addr = {6'd13, 6'd12, 6'd11, 6'd10};
    g_seen = '0;

    // reset with all requests high
    step(); step(); #3;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_enw", {ENW_A, ENW_B}, 2'b00);
    chk("rst_rvalid", rvalid, 4'b0000);
    chk("rst_addr_a", Addr_A, 6'd0);
    step(); RST = 1'b0; #3;
    chk("post_rst_gnt", gnt, 4'b0011);

    // preload 0xA5 at 5 and 0x3C at 9 (rr_ptr now 2)
    step(); req = 4'b0101;
    set_req(0, 1'b1, 6'd5, 8'hA5); set_req(2, 1'b1, 6'd9, 8'h3C); #3;
    chk("preload_gnt", gnt, 4'b0101);
    chk("preload_enw", {ENW_A, ENW_B}, 2'b11);

    // dual read
    step(); we = 4'b0000; #3;
    chk("dual_gnt", gnt, 4'b0101);
    step(); req = 4'b0000; #3;
    chk("dual_rvalid", rvalid, 4'b0101);
    chk("dual_rdata0", rdata[7:0], 8'hA5);
    chk("dual_rdata2", rdata[23:16], 8'h3C);

    // move rr_ptr to 3 then wrap-around
    step(); req = 4'b0100; #3;
    step(); req = 4'b1001; set_req(3, 1'b0, 6'd20, 8'h00); set_req(0, 1'b0, 6'd21, 8'h00); #3;
    chk("wrap_gnt", gnt, 4'b1001);
    chk("wrap_addr_a", Addr_A, 6'd20);
    chk("wrap_addr_b", Addr_B, 6'd21);
    step(); req = 4'b0011; set_req(0, 1'b0, 6'd30, 8'h00); set_req(1, 1'b0, 6'd31, 8'h00); #3;
    chk("wrap_ptr1_addr_a", Addr_A, 6'd31);

    // write/read hazard from rr_ptr=0
    step(); req = 4'b1000; #3;
    step(); req = 4'b0011; set_req(0, 1'b1, 6'd12, 8'h77); set_req(1, 1'b0, 6'd12, 8'h00); #3;
    chk("haz_gnt", gnt, 4'b0001);
    chk("haz_enw_a", ENW_A, 1'b1);
    step(); req = 4'b0010; #3;
    chk("haz_gnt_n1", gnt, 4'b0010);
    step(); req = 4'b0000; #3;
    chk("haz_rvalid", rvalid, 4'b0010);
    chk("haz_rdata1", rdata[15:8], 8'h77);

    // round-robin with all four reading continuously
    step(); req = 4'b1100; we = 4'b0000; #3;
    for (int k = 0; k < 6; k++) begin
      step(); req = 4'b1111; #3;
      chk("rr_gnt", gnt, (k % 2 == 0) ? 4'b0011 : 4'b1100);
    end

    // reset mid-read
    step(); req = 4'b0001; set_req(0, 1'b0, 6'd5, 8'h00); #3;
    chk("midrst_gnt", gnt, 4'b0001);
    step(); RST = 1'b1; req = 4'b0000; #3;
    chk("midrst_rvalid_n1", rvalid, 4'b0000);
    step(); RST = 1'b0; #3;
    chk("midrst_rvalid_n2", rvalid, 4'b0000);

    // randomized traffic under the requester protocol
    g_seen = gnt;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (RST) begin
        if ($urandom_range(0, 1) == 1) RST = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        RST = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i] && g_seen[i]) req[i] = 1'b0;
        if (!req[i] && $urandom_range(0, 9) < 6) begin
          req[i] = 1'b1;
          set_req(i, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
                  8'($urandom));
        end
      end
      #3;
      g_seen = gnt;
    end

    step(); req = 4'b0000; RST = 1'b0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
